// File: rtl/stack_pkg.sv
// Shared types and sizing for the chapter 7 LIFO stack and its pop-side controller.
package stack_pkg;

  localparam int unsigned STACK_DATA_W = 8;
  localparam int unsigned STACK_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    WAIT,
    SEND
  } state_t;

endpackage

// File: rtl/stack_reader.sv
// Pop-side stack controller: drains a burst from the LIFO and streams it out on valid/ready.
module stack_reader
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = STACK_DATA_W,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  output logic              pop,
  input  logic              empty,
  input  logic [DATA_W-1:0] read_data,
  input  logic              stk_error,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  drained
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   drained_q, drained_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               error_q, error_d;
  logic               done_q, done_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    drained_d  = drained_q;
    out_data_d = out_data_q;
    error_d    = error_q;
    done_d     = 1'b0;

    // A start that arrives mid-burst is a protocol error; the burst itself carries on.
    if (start && (state_q != IDLE)) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d   = count;
          drained_d = '0;
          error_d   = 1'b0;
          state_d   = POP;
        end
      end
      POP: begin
        if (empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (stk_error) begin
          error_d = 1'b1;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          out_data_d = read_data;
          drained_d  = drained_q + CNT_W'(1);
          state_d    = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if ((count_q != '0) && (drained_q == count_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = POP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      drained_q  <= '0;
      out_data_q <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      drained_q  <= drained_d;
      out_data_q <= out_data_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  assign pop       = (state_q == POP) && !empty;
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign drained   = drained_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_stack_reader.sv
// Bench for stack_reader paired with a behavioural depth-4 LIFO.
module tb_stack_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] count = '0;
  logic       pop;
  logic       empty;
  logic [7:0] read_data = '0;
  logic       stk_error;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] drained;

  // Stack model controls.
  logic       clr = 1'b0;
  logic       push = 1'b0;
  logic [7:0] wdata = '0;
  logic       force_err = 1'b0;
  logic       model_err = 1'b0;
  logic [7:0] mem [4];
  logic [2:0] sp = '0;

  int pop_cnt = 0;
  logic pop_prev = 1'b0;
  logic pop_twice = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .pop       (pop),
    .empty     (empty),
    .read_data (read_data),
    .stk_error (stk_error),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .drained   (drained)
  );

  assign empty     = (sp == 3'd0);
  assign stk_error = model_err | force_err;

  always @(posedge clk) begin
    model_err <= 1'b0;
    if (clr) begin
      sp <= '0;
    end else if (push && sp < 3'd4) begin
      mem[sp[1:0]] <= wdata;
      sp <= sp + 3'd1;
    end else if (pop) begin
      if (sp == 3'd0) begin
        model_err <= 1'b1;
      end else begin
        read_data <= mem[sp[1:0] - 2'd1];
        sp <= sp - 3'd1;
      end
    end
    if (pop) pop_cnt <= pop_cnt + 1;
    if (pop && pop_prev) pop_twice <= 1'b1;
    pop_prev <= pop;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Empty the model stack, then push 1..n so the top holds n.
  task automatic load(input int n);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 1; i <= n; i++) begin
      push = 1'b1;
      wdata = 8'(i);
      tick();
    end
    push = 1'b0;
  endtask

  task automatic pulse_start(input int c);
    count = 3'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output logic got);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (done) got = 1'b1;
      else tick();
    end
  endtask

  typedef struct {
    int n;         // words preloaded
    int c;         // count request
    int w;         // words expected out
    int done_cyc;  // cycle of done, start sampled at end of cycle 0
    int left;      // stack occupancy afterwards
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic got;
    int   base;

    vecs[0] = '{n: 4, c: 0, w: 4, done_cyc: 14, left: 0};
    vecs[1] = '{n: 4, c: 2, w: 2, done_cyc: 7,  left: 2};
    vecs[2] = '{n: 0, c: 3, w: 0, done_cyc: 2,  left: 0};
    vecs[3] = '{n: 2, c: 3, w: 2, done_cyc: 8,  left: 0};
    vecs[4] = '{n: 3, c: 1, w: 1, done_cyc: 4,  left: 2};
    vecs[5] = '{n: 4, c: 4, w: 4, done_cyc: 13, left: 0};

    // Reset state.
    tick();
    tick();
    chk("reset pop", int'(pop), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset error", int'(error), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset drained", int'(drained), 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      int cyc, nw, dcyc;
      load(vecs[v].n);
      out_ready = 1'b1;
      base = pop_cnt;
      pulse_start(vecs[v].c);
      cyc = 1;
      nw = 0;
      dcyc = -1;
      got = 1'b0;
      for (int k = 0; k < 64 && !got; k++) begin
        if (out_valid) begin
          chk($sformatf("v%0d word%0d data", v, nw), int'(out_data), vecs[v].n - nw);
          chk($sformatf("v%0d word%0d cycle", v, nw), cyc, 3 + 3 * nw);
          nw++;
        end
        if (done) begin
          got = 1'b1;
          dcyc = cyc;
          chk($sformatf("v%0d drained", v), int'(drained), vecs[v].w);
          chk($sformatf("v%0d error", v), int'(error), 0);
        end else begin
          tick();
          cyc++;
        end
      end
      chk($sformatf("v%0d done seen", v), int'(got), 1);
      chk($sformatf("v%0d done cycle", v), dcyc, vecs[v].done_cyc);
      chk($sformatf("v%0d words", v), nw, vecs[v].w);
      chk($sformatf("v%0d pops", v), pop_cnt - base, vecs[v].w);
      chk($sformatf("v%0d stack left", v), int'(sp), vecs[v].left);
      tick();
      chk($sformatf("v%0d done one cycle", v), int'(done), 0);
      chk($sformatf("v%0d idle", v), int'(busy), 0);
    end

    // Back-pressure on the first word.
    load(4);
    out_ready = 1'b0;
    base = pop_cnt;
    pulse_start(0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp valid %0d", k), int'(out_valid), 1);
      chk($sformatf("bp data %0d", k), int'(out_data), 4);
      chk($sformatf("bp pops %0d", k), pop_cnt - base, 1);
      chk($sformatf("bp no pop %0d", k), int'(pop), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp valid dropped after handshake", int'(out_valid), 0);
    chk("bp second pop", int'(pop), 1);
    wait_done(got);
    chk("bp done seen", int'(got), 1);
    chk("bp drained", int'(drained), 4);
    tick();

    // Start while busy: flagged, burst still completes; next start clears it.
    load(2);
    pulse_start(0);
    tick();
    start = 1'b1;
    count = 3'd1;
    tick();
    start = 1'b0;
    chk("proto error set", int'(error), 1);
    chk("proto busy", int'(busy), 1);
    wait_done(got);
    chk("proto done seen", int'(got), 1);
    chk("proto drained", int'(drained), 2);
    chk("proto error held", int'(error), 1);
    tick();
    load(1);
    pulse_start(0);
    chk("proto error cleared", int'(error), 0);
    wait_done(got);
    chk("proto rerun drained", int'(drained), 1);
    tick();

    // Stack error during WAIT.
    load(2);
    pulse_start(0);
    tick();
    force_err = 1'b1;
    tick();
    force_err = 1'b0;
    chk("uf done", int'(done), 1);
    chk("uf error", int'(error), 1);
    chk("uf out_valid", int'(out_valid), 0);
    chk("uf drained", int'(drained), 0);
    chk("uf busy", int'(busy), 0);
    tick();

    // Reset while holding a word in SEND.
    load(4);
    out_ready = 1'b0;
    pulse_start(0);
    tick();
    tick();
    chk("rst pre valid", int'(out_valid), 1);
    rst = 1'b1;
    tick();
    chk("rst pop", int'(pop), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst drained", int'(drained), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rst no late done", int'(done), 0);
    chk("rst stays idle", int'(busy), 0);

    chk("pop never two cycles", int'(pop_twice), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
